// File: rtl/spi_reg_write_controller.sv
// SPI mode-0 initiator that serialises one {R/W, addr[6:0], data[7:0]} register frame per request, MSB first.
// Latency: accept cycle to done pulse = 1 + CS_SETUP + 32*CLK_DIV + CS_HOLD clk cycles; all outputs registered.
// Backpressure: req_ready is high only in IDLE, so a held req_valid waits until the previous frame's GAP ends.
//
// Ports: clk/rst_n (async active-low); req_valid/req_ready/req_addr/req_data request handshake;
//        busy (frame in progress), done (1-cycle completion pulse); sclk/copi/ncs SPI pins.
// Optional macro SPI_CTRL_READBACK_EN adds req_write, cipo and rsp_data for read frames.
module spi_reg_write_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
`ifdef SPI_CTRL_READBACK_EN
    input  logic       req_write,
    input  logic       cipo,
    output logic [7:0] rsp_data,
`endif
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       copi,
    output logic       ncs
);

    // One shared phase counter: sized for the longest phase, reloaded with (length-1) on every phase entry.
    localparam int MAX_A  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_LD = (MAX_A > CS_HOLD) ? MAX_A : CS_HOLD;
    localparam int CW     = (MAX_LD > 1) ? $clog2(MAX_LD) : 1;

    localparam logic [CW-1:0] DIV_LD   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(CS_HOLD - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    bit_idx, bit_idx_nxt;
    logic          phase_hi, phase_hi_nxt;
    logic [15:0]   shreg, shreg_nxt;
    logic          req_ready_nxt, busy_nxt, done_nxt, sclk_nxt, copi_nxt, ncs_nxt;
    logic          frame_wr;
    logic          accept;
    logic          cnt_zero;

`ifdef SPI_CTRL_READBACK_EN
    logic       rd_frame;
    logic [7:0] rx_sh;
    assign frame_wr = req_write;
`else
    assign frame_wr = 1'b1;
`endif

    assign accept   = req_valid && req_ready;
    assign cnt_zero = (cnt == '0);

    // State and datapath registers; pins get the pre-decoded *_nxt values so every output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            phase_hi  <= 1'b0;
            shreg     <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            sclk      <= 1'b0;
            copi      <= 1'b0;
            ncs       <= 1'b1;
`ifdef SPI_CTRL_READBACK_EN
            rd_frame  <= 1'b0;
            rx_sh     <= '0;
            rsp_data  <= '0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            phase_hi  <= phase_hi_nxt;
            shreg     <= shreg_nxt;
            req_ready <= req_ready_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            sclk      <= sclk_nxt;
            copi      <= copi_nxt;
            ncs       <= ncs_nxt;
`ifdef SPI_CTRL_READBACK_EN
            if (accept) begin
                rd_frame <= !req_write;
            end
            // Sample on the clk edge that raises sclk, i.e. the end of the low phase of bits 7..0.
            if (state == SHIFT && !phase_hi && cnt_zero && !bit_idx[3]) begin
                rx_sh <= {rx_sh[6:0], cipo};
            end
            if (state == HOLD && cnt_zero && rd_frame) begin
                rsp_data <= rx_sh;
            end
`endif
        end
    end

    // Next-state and phase sequencing.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        bit_idx_nxt  = bit_idx;
        phase_hi_nxt = phase_hi;
        shreg_nxt    = shreg;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LD;
                    shreg_nxt = {frame_wr, req_addr, req_data};
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_nxt    = SHIFT;
                    cnt_nxt      = DIV_LD;
                    phase_hi_nxt = 1'b0;
                    bit_idx_nxt  = 4'd15;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            SHIFT: begin
                if (!cnt_zero) begin
                    cnt_nxt = cnt - CW'(1);
                end else if (!phase_hi) begin
                    phase_hi_nxt = 1'b1;
                    cnt_nxt      = DIV_LD;
                end else if (bit_idx == 4'd0) begin
                    // Bit 0 stays on copi through HOLD, so no final shift.
                    state_nxt    = HOLD;
                    phase_hi_nxt = 1'b0;
                    cnt_nxt      = HOLD_LD;
                end else begin
                    // Falling edge: the only point where copi advances.
                    phase_hi_nxt = 1'b0;
                    bit_idx_nxt  = bit_idx - 4'd1;
                    shreg_nxt    = {shreg[14:0], 1'b0};
                    cnt_nxt      = DIV_LD;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    state_nxt = GAP;
                    cnt_nxt   = DIV_LD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the next state, registered above.
    always_comb begin
        req_ready_nxt = (state_nxt == IDLE);
        busy_nxt      = (state_nxt != IDLE);
        done_nxt      = (state == HOLD) && (state_nxt == GAP);
        sclk_nxt      = (state_nxt == SHIFT) && phase_hi_nxt;
        ncs_nxt       = 1'b1;
        copi_nxt      = 1'b0;
        if (state_nxt == SETUP || state_nxt == SHIFT || state_nxt == HOLD) begin
            ncs_nxt  = 1'b0;
            copi_nxt = shreg_nxt[15];
        end
    end

endmodule

// File: tb/tb_spi_reg_write_controller.sv
// Bench for spi_reg_write_controller: lane 0 uses the default timing, lane 1 uses CLK_DIV=1, CS_SETUP=1, CS_HOLD=1.
// Each lane has a mode-0 pin decoder and a scoreboard of expected frames, latencies and read responses.
// Directed scenarios are followed by randomized frames, optionally back-to-back.
module tb_spi_reg_write_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] req_valid, req_ready, busy, done, sclk, copi, ncs, req_write;
    logic [6:0] req_addr [2];
    logic [7:0] req_data [2];
`ifdef SPI_CTRL_READBACK_EN
    logic [7:0] rd_pat [2];
`endif

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int D = (g == 0) ? 4 : 1;
        localparam int S = (g == 0) ? 2 : 1;
        localparam int H = (g == 0) ? 2 : 1;
        localparam int LOW_LEN = S + 32 * D + H;

        int          cyc = 0, low_start = 0, high_start = -1, last_done = -1;
        int          redges = 0, viol = 0, ndone = 0;
        logic [15:0] cap;
        logic        psclk, pcopi, pncs;
        logic [15:0] exp_q[$];
        int          acc_q[$];
`ifdef SPI_CTRL_READBACK_EN
        logic       cipo;
        logic [7:0] rsp_data;
        logic [7:0] rsp_model;
        logic [7:0] rsp_q[$];
`endif

        spi_reg_write_controller #(.CLK_DIV(D), .CS_SETUP(S), .CS_HOLD(H)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_addr  (req_addr[g]),
            .req_data  (req_data[g]),
`ifdef SPI_CTRL_READBACK_EN
            .req_write (req_write[g]),
            .cipo      (cipo),
            .rsp_data  (rsp_data),
`endif
            .busy      (busy[g]),
            .done      (done[g]),
            .sclk      (sclk[g]),
            .copi      (copi[g]),
            .ncs       (ncs[g])
        );

        always @(negedge clk) begin
            if (!rst_n) begin
                exp_q.delete();
                acc_q.delete();
                psclk = 1'b0; pcopi = 1'b0; pncs = 1'b1;
                redges = 0; viol = 0; cap = '0; high_start = -1;
`ifdef SPI_CTRL_READBACK_EN
                rsp_q.delete();
                rsp_model = 8'h00;
                cipo = 1'b0;
`endif
            end else begin
                cyc++;
                if (req_valid[g] && req_ready[g]) begin
                    exp_q.push_back({req_write[g], req_addr[g], req_data[g]});
                    acc_q.push_back(cyc);
                    check_eq("accept_while_busy", busy[g], 1'b0);
                    check_eq("accept_after_done", (last_done < 0) || (cyc > last_done), 1'b1);
`ifdef SPI_CTRL_READBACK_EN
                    if (!req_write[g]) rsp_model = rd_pat[g];
                    rsp_q.push_back(rsp_model);
`endif
                end
                if (pncs && !ncs[g]) begin
                    if (high_start >= 0) check_eq("ncs_gap_ge_div", (cyc - high_start) >= D, 1'b1);
                    low_start = cyc;
                    redges = 0; viol = 0; cap = '0;
                end
                if (sclk[g] && !psclk) begin
                    if (ncs[g]) viol++;
                    else begin
                        cap = {cap[14:0], copi[g]};
                        redges++;
                    end
                end
                // While selected, copi may only move on a 1->0 sclk transition.
                if (copi[g] !== pcopi && !ncs[g] && !pncs && !(psclk && !sclk[g])) viol++;
                if (!pncs && ncs[g]) begin
                    high_start = cyc;
                    if (exp_q.size() == 0) check_eq("frame_unexpected", 1'b1, 1'b0);
                    else check_eq("frame_dat", cap, exp_q.pop_front());
                    check_eq("rise_edges", redges, 16);
                    check_eq("ncs_low_len", cyc - low_start, LOW_LEN);
                    check_eq("copi_edge_viol", viol, 0);
                end
                if (done[g]) begin
                    ndone++;
                    last_done = cyc;
                    if (acc_q.size() == 0) check_eq("done_unexpected", 1'b1, 1'b0);
                    else begin
                        check_eq("done_latency", cyc - acc_q.pop_front(), LOW_LEN + 1);
`ifdef SPI_CTRL_READBACK_EN
                        check_eq("rsp_data", rsp_data, rsp_q.pop_front());
`endif
                    end
                end
`ifdef SPI_CTRL_READBACK_EN
                // Present data bit b before the rising edge that samples it (redges == 15-b).
                cipo = (redges >= 8 && redges < 16) ? rd_pat[g][15 - redges] : 1'b0;
`endif
                psclk = sclk[g]; pcopi = copi[g]; pncs = ncs[g];
            end
        end
    end

    task automatic send(input int g, input logic [6:0] a, input logic [7:0] d, input logic w);
        int n;
        @(posedge clk); #1;
        req_valid[g] = 1'b1; req_addr[g] = a; req_data[g] = d; req_write[g] = w;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[g] && n < 2000);
        if (!req_ready[g]) check_eq("accept_timeout", 1'b0, 1'b1);
        @(posedge clk);
    endtask

    // Drop the request and scramble the request bus; the controller must ignore it.
    task automatic release_req(input int g);
        #1;
        req_valid[g] = 1'b0;
        req_addr[g]  = 7'($urandom);
        req_data[g]  = 8'($urandom);
        req_write[g] = 1'($urandom);
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        @(negedge clk);
        while (busy[g] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (busy[g]) check_eq("idle_timeout", busy[g], 1'b0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nd, g;
        logic w;
        logic [6:0] a;
        logic [7:0] d;
        rst_n = 1'b0;
        req_valid = '0;
        req_write = 2'b11;
        req_addr = '{7'h00, 7'h00};
        req_data = '{8'h00, 8'h00};
`ifdef SPI_CTRL_READBACK_EN
        rd_pat = '{8'h00, 8'h00};
`endif
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_req_ready", req_ready[i], 1'b1);
            check_eq("rst_busy", busy[i], 1'b0);
            check_eq("rst_done", done[i], 1'b0);
            check_eq("rst_sclk", sclk[i], 1'b0);
            check_eq("rst_copi", copi[i], 1'b0);
            check_eq("rst_ncs", ncs[i], 1'b1);
        end
`ifdef SPI_CTRL_READBACK_EN
        check_eq("rst_rsp_data", lane[0].rsp_data, 8'h00);
`endif
        rst_n = 1'b1;

        // Frame 0x80FF, then 0xFFA5.
        send(0, 7'h00, 8'hFF, 1'b1); release_req(0); wait_idle(0);
        send(0, 7'h7F, 8'hA5, 1'b1); release_req(0); wait_idle(0);

        // Back-to-back with valid held.
        send(0, 7'h04, 8'h0F, 1'b1);
        send(0, 7'h02, 8'h55, 1'b1);
        release_req(0); wait_idle(0);

        // Reset during bit 7.
        send(0, 7'h12, 8'h34, 1'b1); release_req(0);
        n = 0;
        while (lane[0].redges != 9 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("reached_bit7", lane[0].redges, 9);
        nd = lane[0].ndone;
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_ncs", ncs[0], 1'b1);
        check_eq("midrst_sclk", sclk[0], 1'b0);
        check_eq("midrst_copi", copi[0], 1'b0);
        check_eq("midrst_done", done[0], 1'b0);
        check_eq("midrst_busy", busy[0], 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (150) @(negedge clk);
        check_eq("no_done_after_rst", lane[0].ndone, nd);
        send(0, 7'h01, 8'h3C, 1'b1); release_req(0); wait_idle(0);

        // Fastest timing lane: frame 0x8A12.
        send(1, 7'h0A, 8'h12, 1'b1); release_req(1); wait_idle(1);

`ifdef SPI_CTRL_READBACK_EN
        rd_pat[0] = 8'hC3;
        send(0, 7'h03, 8'h00, 1'b0); release_req(0); wait_idle(0);
        check_eq("rsp_after_read", lane[0].rsp_data, 8'hC3);
        send(0, 7'h03, 8'h99, 1'b1); release_req(0); wait_idle(0);
        check_eq("rsp_after_write", lane[0].rsp_data, 8'hC3);
`endif

        // Randomized frames on both lanes, sometimes back-to-back.
        for (int i = 0; i < 14; i++) begin
            g = $urandom_range(0, 1);
`ifdef SPI_CTRL_READBACK_EN
            rd_pat[g] = 8'($urandom);
`endif
            for (int k = 0; k <= int'($urandom_range(0, 1)); k++) begin
                a = 7'($urandom);
                d = 8'($urandom);
`ifdef SPI_CTRL_READBACK_EN
                w = 1'($urandom);
`else
                w = 1'b1;
`endif
                send(g, a, d, w);
            end
            release_req(g);
            wait_idle(g);
        end

        check_eq("lane0_pending", lane[0].acc_q.size(), 0);
        check_eq("lane1_pending", lane[1].acc_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
